// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// error codes and memory geometry.
package imem_boot_loader_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States that consume the byte stream; also the states where the CPU address port is owned
  function automatic logic is_busy_state(input state_e s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_boot_loader_timeout.sv
// Idle-cycle watchdog for the loader: cleared on every transfer or new load,
// flags expiry on the cycle the idle count reaches TIMEOUT_CYC.
module boot_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable & (r_count == LAST_IDLE);

  // Idle-cycle counter; clear has priority so a transfer always resets the window
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte frame, writes it
// as 16-bit words to instruction memory and releases the CPU on success.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  input  logic [8:0]  i_fetch_addr,
  output logic [8:0]  o_mem_addr,
  output logic        o_imem_we,
  output logic [15:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_err
);

  localparam logic [15:0] W_DEPTH = 16'(DEPTH_WORDS);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_len_hi;
  logic [8:0]  r_len;
  logic [7:0]  r_hi;
  logic [7:0]  r_csum;
  logic [8:0]  r_word_idx;
  logic        r_we;
  logic [15:0] r_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic [1:0]  r_err;

  logic        w_busy;
  logic        w_xfer;
  logic        w_start_acc;
  logic        w_expired;
  logic        w_err_set;
  logic [1:0]  w_err_code;
  logic [15:0] w_len_full;

  assign w_busy      = is_busy_state(r_state);
  assign w_xfer      = i_rx_valid & w_busy;
  assign w_start_acc = i_start & ~w_busy;
  assign w_len_full  = {r_len_hi, i_rx_data};

  boot_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_start_acc | w_xfer),
    .i_enable  (w_busy & ~w_xfer),
    .o_expired (w_expired)
  );

  // Next-state and error-code selection; expiry implies no transfer this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_err_code  = ERR_NONE;
    if (w_expired) begin
      w_state_nxt = ST_ERROR;
      w_err_set   = 1'b1;
      w_err_code  = ERR_TIMEOUT;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) w_state_nxt = ST_LEN_HI;
          else         w_state_nxt = r_state;
        end
        ST_LEN_HI: begin
          if (w_xfer) w_state_nxt = ST_LEN_LO;
          else        w_state_nxt = r_state;
        end
        ST_LEN_LO: begin
          if (!w_xfer) begin
            w_state_nxt = r_state;
          end else if (w_len_full == 16'd0) begin
            w_state_nxt = ST_CHECK;
          end else if (w_len_full > W_DEPTH) begin
            w_state_nxt = ST_ERROR;
            w_err_set   = 1'b1;
            w_err_code  = ERR_LEN;
          end else begin
            w_state_nxt = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (w_xfer) w_state_nxt = ST_DATA_LO;
          else        w_state_nxt = r_state;
        end
        ST_DATA_LO: begin
          // word_idx still points at this word; it advances during the write cycle
          if (!w_xfer)                           w_state_nxt = r_state;
          else if (r_word_idx + 9'd1 == r_len)   w_state_nxt = ST_CHECK;
          else                                   w_state_nxt = ST_DATA_HI;
        end
        ST_CHECK: begin
          if (!w_xfer) begin
            w_state_nxt = r_state;
          end else if (i_rx_data == r_csum) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ERROR;
            w_err_set   = 1'b1;
            w_err_code  = ERR_CSUM;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, datapath and sticky status registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_len_hi   <= 8'd0;
      r_len      <= 9'd0;
      r_hi       <= 8'd0;
      r_csum     <= 8'd0;
      r_word_idx <= 9'd0;
      r_we       <= 1'b0;
      r_wdata    <= 16'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      if (w_start_acc) begin
        r_done     <= 1'b0;
        r_err      <= ERR_NONE;
        r_csum     <= 8'd0;
        r_word_idx <= 9'd0;
        r_cpu_hold <= 1'b1;
      end
      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI: r_len_hi <= i_rx_data;
          ST_LEN_LO: r_len    <= w_len_full[8:0];
          ST_DATA_HI: begin
            r_hi   <= i_rx_data;
            r_csum <= r_csum ^ i_rx_data;
          end
          ST_DATA_LO: begin
            r_we    <= 1'b1;
            r_wdata <= {r_hi, i_rx_data};
            r_csum  <= r_csum ^ i_rx_data;
          end
          default: ;
        endcase
      end
      if (r_we) begin
        r_word_idx <= r_word_idx + 9'd1;
      end
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= w_err_code;
      end
    end
  end

  assign o_rx_ready   = w_busy;
  assign o_busy       = w_busy;
  assign o_mem_addr   = w_busy ? {r_word_idx[7:0], 1'b0} : i_fetch_addr;
  assign o_imem_we    = r_we;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of directed frames, random
// frames against a frame-level reference model, and multi-cycle corner sequences.
module tb_imem_boot_loader;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [8:0]  fetch_addr = 9'h0AB;
  logic        rx_ready, imem_we, cpu_hold, busy, done;
  logic [8:0]  mem_addr;
  logic [15:0] imem_wdata;
  logic [1:0]  err;

  imem_boot_loader #(.DEPTH_WORDS(256), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_valid(rx_valid),
    .i_rx_data(rx_data), .o_rx_ready(rx_ready), .i_fetch_addr(fetch_addr),
    .o_mem_addr(mem_addr), .o_imem_we(imem_we), .o_imem_wdata(imem_wdata),
    .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    logic [63:0] bytes; int nb; bit bp; bit e_done; logic [1:0] e_err; int e_nwr;
  } vec_t;

  wr_t        exp_wr[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         wr_count = 0;
  logic [8:0] last_wr_addr = 9'd0;
  logic       prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must be a single cycle and match the scoreboard head
  always @(negedge clk) begin
    if (imem_we) begin
      wr_t e;
      wr_count++;
      last_wr_addr = mem_addr;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, imem_wdata);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", {23'd0, mem_addr}, {23'd0, e.addr});
        check("wr_data", {16'd0, imem_wdata}, {16'd0, e.data});
      end
    end
    prev_we = imem_we;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rx_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    check("rx_ready_wait", {31'd0, got}, 32'd1);
  endtask

  // Reference model: parse the frame by its rules, queue expected writes, predict outcome
  task automatic model_frame(input logic [7:0] f[$], output int ncons,
                             output bit e_done, output logic [1:0] e_err);
    int n;
    logic [7:0] cs;
    wr_t w;
    n = int'({f[0], f[1]});
    if (n > 256) begin
      ncons = 2; e_done = 1'b0; e_err = 2'd1;
    end else begin
      cs = 8'd0;
      for (int i = 0; i < n; i++) begin
        w.addr = 9'(2 * i);
        w.data = {f[2 + 2*i], f[3 + 2*i]};
        cs = cs ^ f[2 + 2*i] ^ f[3 + 2*i];
        exp_wr.push_back(w);
      end
      ncons  = 3 + 2*n;
      e_done = (f[2 + 2*n] == cs);
      e_err  = e_done ? 2'd0 : 2'd2;
    end
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit bp,
                           output bit e_done, output logic [1:0] e_err);
    int ncons;
    model_frame(f, ncons, e_done, e_err);
    pulse_start();
    for (int i = 0; i < ncons; i++) begin
      if (bp) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      send_byte(f[i]);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_outcome(input bit e_done, input logic [1:0] e_err);
    @(negedge clk);
    check("done", {31'd0, done}, {31'd0, e_done});
    check("err", {30'd0, err}, {30'd0, e_err});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, ~e_done});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("rx_ready_end", {31'd0, rx_ready}, 32'd0);
    check("pending_writes", exp_wr.size(), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] f[$];
    bit m_done;
    logic [1:0] m_err;
    int wr0;
    logic [7:0] cs, b;
    int n;
    logic [15:0] nlen;
    wr_t w;

    vecs[0] = '{64'h00021234ABCD4000, 7, 1'b0, 1'b1, 2'd0, 2};
    vecs[1] = '{64'h00021234ABCD4100, 7, 1'b0, 1'b0, 2'd2, 2};
    vecs[2] = '{64'h0101000000000000, 2, 1'b0, 1'b0, 2'd1, 0};
    vecs[3] = '{64'h0000000000000000, 3, 1'b0, 1'b1, 2'd0, 0};
    vecs[4] = '{64'h00021234ABCD4000, 7, 1'b1, 1'b1, 2'd0, 2};
    vecs[5] = '{64'h0001FF00FF000000, 5, 1'b1, 1'b1, 2'd0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_mem_addr", {23'd0, mem_addr}, 32'h0AB);
    @(posedge clk); #1 rst = 1'b0;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      f.delete();
      for (int i = 0; i < vecs[v].nb; i++) f.push_back(vecs[v].bytes[63 - 8*i -: 8]);
      wr0 = wr_count;
      run_frame(f, vecs[v].bp, m_done, m_err);
      check_outcome(vecs[v].e_done, vecs[v].e_err);
      check("write_count", wr_count - wr0, vecs[v].e_nwr);
      if (v == 0) begin
        fetch_addr = 9'h004;
        #1 check("fetch_passthru", {23'd0, mem_addr}, 32'h004);
      end
    end

    // Full-depth load
    f.delete();
    f.push_back(8'h01); f.push_back(8'h00);
    cs = 8'd0;
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      f.push_back(b);
    end
    f.push_back(cs);
    wr0 = wr_count;
    run_frame(f, 1'b0, m_done, m_err);
    check_outcome(1'b1, 2'd0);
    check("full_write_count", wr_count - wr0, 32'd256);
    check("full_last_addr", {23'd0, last_wr_addr}, 32'h1FE);
    fetch_addr = 9'($urandom);
    #1 check("fetch_passthru_rand", {23'd0, mem_addr}, {23'd0, fetch_addr});

    // Random frames against the model
    for (int it = 0; it < 8; it++) begin
      f.delete();
      if (it == 0) begin
        nlen = 16'($urandom_range(257, 65535));
        f.push_back(nlen[15:8]); f.push_back(nlen[7:0]);
      end else begin
        n = $urandom_range(1, 12);
        f.push_back(8'd0); f.push_back(8'(n));
        cs = 8'd0;
        for (int i = 0; i < 2*n; i++) begin
          b = 8'($urandom);
          cs = cs ^ b;
          f.push_back(b);
        end
        if ($urandom_range(0, 1) == 1) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        f.push_back(cs);
      end
      run_frame(f, 1'($urandom_range(0, 1)), m_done, m_err);
      check_outcome(m_done, m_err);
    end

    // Stall after three bytes until the watchdog fires
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    check("tmo_not_yet_busy", {31'd0, busy}, 32'd1);
    check("tmo_not_yet_err", {30'd0, err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tmo_err", {30'd0, err}, 32'd3);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);

    // A byte arriving on the expiry cycle wins over the timeout
    pulse_start();
    w.addr = 9'h000; w.data = 16'hABCD; exp_wr.push_back(w);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send_byte(8'hCD);
    send_byte(8'h66);
    repeat (3) @(posedge clk);
    check_outcome(1'b1, 2'd0);

    // Start pulsed mid-frame is ignored
    pulse_start();
    w.addr = 9'h000; w.data = 16'h5566; exp_wr.push_back(w);
    send_byte(8'h00); send_byte(8'h01);
    pulse_start();
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h33);
    repeat (3) @(posedge clk);
    check_outcome(1'b1, 2'd0);

    // Reset while a DATA_LO byte is being presented
    pulse_start();
    w.addr = 9'h000; w.data = 16'h1234; exp_wr.push_back(w);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    rx_valid = 1'b1; rx_data = 8'hCD; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
    repeat (4) @(posedge clk);
    check("mid_rst_pending", exp_wr.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
